pow_accelerator: RTL and testbench
==================================

POW_ACCELERATOR -- requirements
Module: pow_accelerator

Interface
REQ-001 SHALL have parameter WIDTH, default 32: width of base x and result p.
REQ-002 SHALL have parameter EXP_WIDTH, default 32: width of exponent a.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = truncate on overflow, 1 = clamp p to all-ones on overflow.
REQ-004 SHALL have port clock, input, 1: single clock, all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: start request, sampled only while ready=1.
REQ-007 SHALL have port x, input, WIDTH: base operand.
REQ-008 SHALL have port a, input, EXP_WIDTH: exponent operand.
REQ-009 SHALL have port ready, output, 1: high when idle and able to accept enable.
REQ-010 SHALL have port done, output, 1: one-cycle pulse marking a valid result.
REQ-011 SHALL have port p, output, WIDTH: result x^a, truncated or saturated.
REQ-012 SHALL have port overflow, output, 1: high if true x^a exceeds 2^WIDTH-1; valid with p.

Function
REQ-013 SHALL implement two states: IDLE (ready=1) and RUN (ready=0).
REQ-014 SHALL, on a rising edge in IDLE with enable=1, capture x into base register b, a into remaining-exponent register e, set accumulator r=1, clear internal base-overflow flag bo, clear overflow, and enter RUN.
REQ-015 SHALL ignore enable while in RUN; captured operands are not disturbed.
REQ-016 SHALL, on each RUN edge with e!=0, perform one right-to-left square-and-multiply iteration: if e[0]=1 then r<=low WIDTH bits of r*b; b<=low WIDTH bits of b*b; e<=e>>1.
REQ-017 SHALL set overflow sticky during an iteration with e[0]=1 if the upper WIDTH bits of r*b are nonzero or bo=1.
REQ-018 SHALL set bo sticky when the upper WIDTH bits of b*b are nonzero.
REQ-019 SHALL, on the RUN edge with e=0, load p with r (or all-ones if SATURATE=1 and overflow=1), pulse done for exactly the following cycle, and return to IDLE with ready=1.
REQ-020 SHALL have latency n+1 edges from the capturing edge to the edge asserting done, where n = index of the most significant set bit of a plus one (n=0 for a=0).
REQ-021 SHALL hold p and overflow stable from done until the next accepted enable.
REQ-022 SHALL define x^0=1 for all x including x=0, with overflow=0.
REQ-023 SHALL produce p=0 with overflow=0 for x=0, a>0, and p=1 with overflow=0 for x=1.
REQ-024 SHALL allow enable in the same cycle done is high; it is accepted because ready=1, starting a new operation back-to-back.
REQ-025 SHALL form products at 2*WIDTH bits unsigned; all arithmetic SHALL be unsigned.

Reset
REQ-026 SHALL, while reset=1, force state IDLE, ready=1, done=0, p=0, overflow=0, and r, b, e, bo to 0, regardless of clock.
REQ-027 SHALL abort any RUN in progress on reset with no done pulse; the first operation after reset release SHALL behave as if no prior operation existed.

Verification
REQ-028 x=3, a=5, WIDTH=32 -> done 4 edges after capture, p=243, overflow=0.
REQ-029 x=2, a=31 -> p=0x80000000, overflow=0; x=2, a=32 -> overflow=1, p=0 with SATURATE=0, p=0xFFFFFFFF with SATURATE=1.
REQ-030 x=5, a=50 -> done 7 edges after capture, overflow=1, p = 5^50 mod 2^32 from reference model.
REQ-031 x=0, a=0 -> done 1 edge after capture, p=1, overflow=0; x=0, a=7 -> p=0, overflow=0.
REQ-032 enable pulsed during RUN ignored; enable asserted during the done cycle starts a second operation with correct result.
REQ-033 reset asserted mid-RUN -> ready=1, p=0, overflow=0 immediately, no done pulse; subsequent x=3, a=5 -> p=243.

Source files
------------

// File: rtl/pow_accelerator.sv
// rtl/pow_accelerator.sv - sequential x^a engine using right-to-left square-and-multiply
module pow_accelerator #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = 32,
  parameter int SATURATE  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WIDTH-1:0]     x,
  input  logic [EXP_WIDTH-1:0] a,
  output logic                 ready,
  output logic                 done,
  output logic [WIDTH-1:0]     p,
  output logic                 overflow
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  state_t               next_state;
  logic [WIDTH-1:0]     r;
  logic [WIDTH-1:0]     b;
  logic [EXP_WIDTH-1:0] e;
  logic                 bo;
  logic [2*WIDTH-1:0]   rb;
  logic [2*WIDTH-1:0]   bb;

  // Full-width unsigned products; upper halves reveal lost bits
  assign rb = {{WIDTH{1'b0}}, r} * {{WIDTH{1'b0}}, b};
  assign bb = {{WIDTH{1'b0}}, b} * {{WIDTH{1'b0}}, b};

  assign ready = (state == IDLE);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state: start on enable while idle, finish once the exponent is consumed
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (enable) next_state = RUN;
      RUN:     if (e == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, one square-and-multiply step per cycle, result load
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r        <= '0;
      b        <= '0;
      e        <= '0;
      bo       <= 1'b0;
      p        <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            b        <= x;
            e        <= a;
            r        <= {{(WIDTH-1){1'b0}}, 1'b1};
            bo       <= 1'b0;
            overflow <= 1'b0;
          end
        end
        RUN: begin
          if (e != '0) begin
            if (e[0]) begin
              r <= rb[WIDTH-1:0];
              // A truncated base already exceeds the range, so any use of it overflows
              if ((rb[2*WIDTH-1:WIDTH] != '0) || bo) overflow <= 1'b1;
            end
            b <= bb[WIDTH-1:0];
            if (bb[2*WIDTH-1:WIDTH] != '0) bo <= 1'b1;
            e <= e >> 1;
          end else begin
            p    <= ((SATURATE != 0) && overflow) ? '1 : r;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pow_accelerator.sv
// tb/tb_pow_accelerator.sv - scoreboard bench for pow_accelerator, truncating and saturating builds
module tb_pow_accelerator;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [31:0] x;
  logic [31:0] a;
  logic        ready, done, overflow;
  logic [31:0] p;
  logic        ready_s, done_s, overflow_s;
  logic [31:0] p_s;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  typedef struct {
    logic [31:0] p;
    logic        ov;
    int          lat;
    int          cap;
  } exp_t;

  exp_t sb[$];

  pow_accelerator #(.WIDTH(32), .EXP_WIDTH(32), .SATURATE(0)) dut (
    .clock(clock), .reset(reset), .enable(enable), .x(x), .a(a),
    .ready(ready), .done(done), .p(p), .overflow(overflow)
  );

  pow_accelerator #(.WIDTH(32), .EXP_WIDTH(32), .SATURATE(1)) dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .x(x), .a(a),
    .ready(ready_s), .done(done_s), .p(p_s), .overflow(overflow_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference by repeated multiplication, tracking whether the true value left the range
  function automatic exp_t model(input logic [31:0] xv, input logic [31:0] av);
    exp_t        m;
    logic [63:0] val;
    logic [63:0] prod;
    logic [31:0] t;
    int          n;
    val  = 64'd1;
    m.ov = 1'b0;
    for (int i = 0; i < int'(av); i++) begin
      prod = val * {32'd0, xv};
      if (prod[63:32] != 32'd0) m.ov = 1'b1;
      val = {32'd0, prod[31:0]};
    end
    m.p = val[31:0];
    n = 0;
    t = av;
    while (t != 32'd0) begin
      n++;
      t = t >> 1;
    end
    m.lat = n + 1;
    m.cap = 0;
    return m;
  endfunction

  // Called at a negedge; drives a request, logs its expectation, releases enable a cycle later
  task automatic issue(input logic [31:0] xv, input logic [31:0] av);
    exp_t m;
    int   guard;
    guard = 0;
    while (!ready && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    check("ready_timeout", {63'd0, ready}, 64'd1);
    m     = model(xv, av);
    m.cap = cycle + 1;
    sb.push_back(m);
    x      = xv;
    a      = av;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (!done && guard < 500) begin
      @(negedge clock);
      guard++;
    end
    check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    check("drain", sb.size(), 0);
  endtask

  // Monitor: every done must match the oldest outstanding request
  always @(negedge clock) begin
    if (!reset && done) begin
      exp_t m;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        m = sb.pop_front();
        check("p", p, m.p);
        check("overflow", overflow, m.ov);
        check("latency", cycle - m.cap, m.lat);
        check("p_sat", p_s, m.ov ? 32'hFFFF_FFFF : m.p);
        check("overflow_sat", overflow_s, m.ov);
        check("done_sat", done_s, 1'b1);
        check("ready_at_done", ready, 1'b1);
      end
    end
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    x      = '0;
    a      = '0;
    #2;
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_p", p, 32'd0);
    check("rst_overflow", overflow, 1'b0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    issue(32'd3, 32'd5);
    drain();
    issue(32'd2, 32'd31);
    issue(32'd2, 32'd32);
    issue(32'd5, 32'd50);
    issue(32'd0, 32'd0);
    issue(32'd0, 32'd7);
    issue(32'd1, 32'd63);
    issue(32'hFFFF_FFFF, 32'd1);
    issue(32'hFFFF_FFFF, 32'd0);
    drain();

    // Output holds after done until the next accepted request
    repeat (3) @(negedge clock);
    check("hold_p", p, 32'd1);
    check("hold_overflow", overflow, 1'b0);

    // Requests during RUN are ignored
    issue(32'd7, 32'd20);
    @(negedge clock);
    x      = 32'd9;
    a      = 32'd3;
    enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    check("busy_ready", ready, 1'b0);
    // Back-to-back: request in the done cycle
    wait_done();
    issue(32'd6, 32'd11);
    drain();

    for (int i = 0; i < 16; i++) begin
      logic [31:0] xv;
      case (i % 3)
        0:       xv = $urandom_range(0, 3);
        1:       xv = $urandom_range(0, 40);
        default: xv = $urandom;
      endcase
      issue(xv, $urandom_range(0, 70));
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    drain();

    // Reset in the middle of a run aborts without a done pulse
    issue(32'd3, 32'd50);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_ready", ready, 1'b1);
    check("abort_p", p, 32'd0);
    check("abort_overflow", overflow, 1'b0);
    check("abort_done", done, 1'b0);
    sb.delete();
    repeat (3) begin
      @(negedge clock);
      check("abort_no_done", done, 1'b0);
    end
    reset = 1'b0;
    @(negedge clock);
    issue(32'd3, 32'd5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
